trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameters, one per line as name, default, meaning: VEC_BUSERR, 16'o000004, bus-error vector; VEC_ERR, 16'o000010, illegal/reserved-instruction vector; VEC_TRACE, 16'o000014, T-bit trace vector; IRQ_PRIO, 3'd4, priority level of the external interrupt line.
REQ-002 Ports, one per line as name, direction, width, meaning. Clock and reset come first.
- clk, in, 1: single clock; all state is updated on its rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- ce, in, 1: clock enable; no state changes when low.
- boundary, in, 1: the control unit is at an instruction boundary; arbitration is allowed.
- req_buserr, in, 1: bus-error pulse, latched.
- req_err, in, 1: illegal-instruction pulse, latched.
- irq, in, 1: external interrupt request, level.
- irq_vec, in, 16: vector supplied with irq.
- psw, in, 8: current {priority[2:0], T, N, Z, V, C}.
- sp, in, 16: current R6.
- pc, in, 16: current R7.
- bus_req, out, 1: bus cycle request.
- bus_we, out, 1: 1 = write.
- bus_addr, out, 16: word address.
- bus_wdata, out, 16: write data.
- bus_ack, in, 1: cycle complete; bus_rdata valid.
- bus_rdata, in, 16: read data.
- bus_err, in, 1: qualifies bus_ack as failed.
- sp_load, out, 1: one-cycle strobe; load sp_out into R6.
- sp_out, out, 16: new SP value.
- pc_load, out, 1: one-cycle strobe; load pc_out into R7.
- pc_out, out, 16: new PC value.
- psw_load, out, 1: one-cycle strobe; load psw_out into the PSW.
- psw_out, out, 8: new PSW value.
- irq_ack, out, 1: one-cycle strobe; IRQ accepted.
- busy, out, 1: sequence in progress; the control unit stalls.
- done, out, 1: one-cycle strobe; sequence complete.
- halted, out, 1: double fault.

Function
REQ-003 All state advances, strobes and handshake sampling SHALL occur only on clk edges with ce=1; strobes last exactly one ce-qualified cycle.
REQ-004 Pending latches: req_buserr and req_err SHALL each set a sticky pending bit; a pending bit clears only on the cycle its vector is selected.
REQ-005 Pending trace SHALL equal psw[4]; pending IRQ SHALL equal irq AND (psw[7:5] < IRQ_PRIO).
REQ-006 Arbitration SHALL occur in IDLE when ce and boundary are high and any source is pending.
REQ-007 Arbitration priority SHALL be fixed: buserr > err > trace > irq. Exactly one source is selected; the others stay pending.
REQ-008 On selection the block SHALL:
- latch vec, latch psw and pc as saved_psw and saved_pc, and latch sp as the working sp;
- assert busy from the next cycle;
- pulse irq_ack in the selection cycle only if irq is selected;
- irq_vec is sampled in the selection cycle.
REQ-009 States SHALL be IDLE, PUSH_PSW, PUSH_PC, FETCH_PC, FETCH_PSW, DONE and HALT. Selection leads IDLE to PUSH_PSW.
REQ-010 PUSH_PSW SHALL write {8'b0, saved_psw} to address sp-2. PUSH_PC SHALL write saved_pc to address sp-4.
REQ-011 FETCH_PC SHALL read vec. FETCH_PSW SHALL read vec+2.
REQ-012 Addresses SHALL wrap modulo 2^16. Bit 0 of each computed address SHALL be forced to 0.
REQ-013 Bus handshake:
- In each bus state, bus_req=1 with bus_we, bus_addr and bus_wdata held stable until a cycle with bus_ack=1.
- The state advances on the edge where bus_ack=1.
- bus_req SHALL be 0 in IDLE, DONE and HALT.
- bus_ack is ignored while bus_req=0.
REQ-014 Each push SHALL pulse sp_load on its ack cycle, with sp_out equal to the address just written.
REQ-015 The FETCH_PC ack SHALL pulse pc_load with pc_out=bus_rdata. The FETCH_PSW ack SHALL pulse psw_load with psw_out=bus_rdata[7:0].
REQ-016 DONE SHALL last one cycle: done=1, busy=1, then IDLE. Back-to-back sequences are therefore separated by at least one IDLE cycle.
REQ-017 bus_ack together with bus_err in any bus state SHALL enter HALT: halted=1, busy=1, no further bus cycles, no strobes.
REQ-018 HALT is left only by reset.
REQ-019 A bus error raised by the sequence's own cycle SHALL NOT set the buserr pending bit. An external req_buserr arriving during a sequence stays pending for the next boundary.
REQ-020 The simultaneous event of a req_* pulse on the arbitration cycle SHALL be latched and participate in that same arbitration.

Reset
REQ-021 On reset_n=0 at a clk edge, independent of ce, the block SHALL:
- enter IDLE;
- clear all pending bits, halted and the saved registers;
- set every output to 0.
REQ-022 Reset applied mid-sequence SHALL abandon the bus cycle immediately: bus_req=0 on the following cycle, with no strobes.

Verification
REQ-023 Illegal-instruction trap. Stimulus: sp=0o001000, pc=0o002000, psw=0o000, mem[0o10]=0o003000, mem[0o12]=0o000340, req_err pulse at boundary. Response:
- writes 0o000000 to 0o000776, then 0o002000 to 0o000774;
- sp_out 0o000776, then 0o000774;
- pc_out 0o003000 and psw_out 0o340;
- done once.
REQ-024 IRQ masking. Stimulus: irq=1, irq_vec=0o000060, psw=0o200. Response: no sequence. Then psw=0o340: still none. Then psw=0o000: irq_ack=1 and reads from 0o000060 and 0o000062.
REQ-025 Priority. Stimulus: req_buserr and req_err pulsed on the same cycle. Response: first sequence reads 0o000004; second sequence at the next boundary reads 0o000010.
REQ-026 Double fault. Stimulus: bus_err with the ack of PUSH_PC. Response: halted=1, bus_req=0 thereafter, no pc_load; cleared only by reset_n=0.
REQ-027 Stalls and wrap. Stimulus: ce toggling 1/0 and bus_ack delayed 3 cycles, with sp=0o000002. Response: outputs stable while waiting; push addresses 0o000000 and 0o177776.
REQ-028 Reset mid-sequence. Stimulus: reset_n=0 during FETCH_PC. Response: next cycle busy=0, bus_req=0, and no pending bits remain.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap/interrupt entry sequencer: arbitrates pending trap sources at an instruction
// boundary, pushes PSW and PC, then fetches the new PC/PSW pair from the vector.
module trap_sequencer #(
   parameter logic [15:0] VEC_BUSERR = 16'o000004,
   parameter logic [15:0] VEC_ERR    = 16'o000010,
   parameter logic [15:0] VEC_TRACE  = 16'o000014,
   parameter logic [2:0]  IRQ_PRIO   = 3'd4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce,
   input  logic        boundary,
   input  logic        req_buserr,
   input  logic        req_err,
   input  logic        irq,
   input  logic [15:0] irq_vec,
   input  logic [7:0]  psw,
   input  logic [15:0] sp,
   input  logic [15:0] pc,
   output logic        bus_req,
   output logic        bus_we,
   output logic [15:0] bus_addr,
   output logic [15:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [15:0] bus_rdata,
   input  logic        bus_err,
   output logic        sp_load,
   output logic [15:0] sp_out,
   output logic        pc_load,
   output logic [15:0] pc_out,
   output logic        psw_load,
   output logic [7:0]  psw_out,
   output logic        irq_ack,
   output logic        busy,
   output logic        done,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_PSW,
      S_PUSH_PC,
      S_FETCH_PC,
      S_FETCH_PSW,
      S_DONE,
      S_HALT
   } state_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } bus_cmd_t;

   state_t      state, state_nxt;
   logic        pend_buserr, pend_err;
   logic [15:0] vec, saved_pc, work_sp;
   logic [7:0]  saved_psw;

   logic        src_buserr, src_err, src_trace, src_irq;
   logic        arb;
   logic        sel_buserr, sel_err, sel_trace, sel_irq;
   logic [15:0] sel_vec;
   logic [15:0] push_addr, vec_addr, vec2_addr;
   logic        in_push;
   bus_cmd_t    cmd;
   logic        ack_ok, ack_bad;

   // A request pulse on the arbitration cycle itself competes immediately.
   assign src_buserr = pend_buserr | req_buserr;
   assign src_err    = pend_err | req_err;
   assign src_trace  = psw[4];
   assign src_irq    = irq && (psw[7:5] < IRQ_PRIO);

   assign arb = reset_n && ce && boundary && (state == S_IDLE) &&
                (src_buserr || src_err || src_trace || src_irq);

   assign sel_buserr = arb && src_buserr;
   assign sel_err    = arb && !src_buserr && src_err;
   assign sel_trace  = arb && !src_buserr && !src_err && src_trace;
   assign sel_irq    = arb && !src_buserr && !src_err && !src_trace && src_irq;

   always_comb begin
      sel_vec = irq_vec;
      if (src_buserr)     sel_vec = VEC_BUSERR;
      else if (src_err)   sel_vec = VEC_ERR;
      else if (src_trace) sel_vec = VEC_TRACE;
   end

   // work_sp tracks the stack as it is pushed, so both pushes use work_sp-2.
   assign push_addr = (work_sp - 16'd2) & 16'hFFFE;
   assign vec_addr  = vec & 16'hFFFE;
   assign vec2_addr = (vec + 16'd2) & 16'hFFFE;
   assign in_push   = (state == S_PUSH_PSW) || (state == S_PUSH_PC);

   always_comb begin
      cmd = '0;
      case (state)
         S_PUSH_PSW:  cmd = '{req: 1'b1, we: 1'b1, addr: push_addr, wdata: {8'h00, saved_psw}};
         S_PUSH_PC:   cmd = '{req: 1'b1, we: 1'b1, addr: push_addr, wdata: saved_pc};
         S_FETCH_PC:  cmd = '{req: 1'b1, we: 1'b0, addr: vec_addr,  wdata: 16'h0000};
         S_FETCH_PSW: cmd = '{req: 1'b1, we: 1'b0, addr: vec2_addr, wdata: 16'h0000};
         default:     cmd = '0;
      endcase
   end

   assign ack_ok  = reset_n && ce && cmd.req && bus_ack && !bus_err;
   assign ack_bad = reset_n && ce && cmd.req && bus_ack && bus_err;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (arb) state_nxt = S_PUSH_PSW;
         S_PUSH_PSW:  if (ack_bad) state_nxt = S_HALT; else if (ack_ok) state_nxt = S_PUSH_PC;
         S_PUSH_PC:   if (ack_bad) state_nxt = S_HALT; else if (ack_ok) state_nxt = S_FETCH_PC;
         S_FETCH_PC:  if (ack_bad) state_nxt = S_HALT; else if (ack_ok) state_nxt = S_FETCH_PSW;
         S_FETCH_PSW: if (ack_bad) state_nxt = S_HALT; else if (ack_ok) state_nxt = S_DONE;
         S_DONE:      state_nxt = S_IDLE;
         S_HALT:      state_nxt = S_HALT;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= S_IDLE;
      else if (ce)
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_buserr <= 1'b0;
         pend_err    <= 1'b0;
         vec         <= 16'h0000;
         saved_psw   <= 8'h00;
         saved_pc    <= 16'h0000;
         work_sp     <= 16'h0000;
      end else if (ce) begin
         pend_buserr <= src_buserr && !sel_buserr;
         pend_err    <= src_err && !sel_err;
         if (arb) begin
            vec       <= sel_vec;
            saved_psw <= psw;
            saved_pc  <= pc;
            work_sp   <= sp;
         end else if (ack_ok && in_push) begin
            work_sp   <= push_addr;
         end
      end
   end

   assign bus_req   = cmd.req;
   assign bus_we    = cmd.we;
   assign bus_addr  = cmd.addr;
   assign bus_wdata = cmd.wdata;

   assign sp_load  = ack_ok && in_push;
   assign sp_out   = sp_load ? push_addr : 16'h0000;
   assign pc_load  = ack_ok && (state == S_FETCH_PC);
   assign pc_out   = pc_load ? bus_rdata : 16'h0000;
   assign psw_load = ack_ok && (state == S_FETCH_PSW);
   assign psw_out  = psw_load ? bus_rdata[7:0] : 8'h00;

   assign irq_ack = sel_irq;
   assign busy    = (state != S_IDLE);
   assign done    = reset_n && ce && (state == S_DONE);
   assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: word memory responder with programmable ack
// delay and error injection, plus a monitor logging bus cycles and strobes.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b1;
   logic        boundary = 1'b0;
   logic        req_buserr = 1'b0;
   logic        req_err = 1'b0;
   logic        irq = 1'b0;
   logic [15:0] irq_vec = 16'h0;
   logic [7:0]  psw = 8'h0;
   logic [15:0] sp = 16'h0;
   logic [15:0] pc = 16'h0;
   logic        bus_req, bus_we;
   logic [15:0] bus_addr, bus_wdata;
   logic        bus_ack = 1'b0;
   logic [15:0] bus_rdata = 16'h0;
   logic        bus_err = 1'b0;
   logic        sp_load, pc_load, psw_load, irq_ack, busy, done, halted;
   logic [15:0] sp_out, pc_out;
   logic [7:0]  psw_out;

   trap_sequencer dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .boundary(boundary),
      .req_buserr(req_buserr), .req_err(req_err), .irq(irq), .irq_vec(irq_vec),
      .psw(psw), .sp(sp), .pc(pc),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
      .sp_load(sp_load), .sp_out(sp_out), .pc_load(pc_load), .pc_out(pc_out),
      .psw_load(psw_load), .psw_out(psw_out), .irq_ack(irq_ack),
      .busy(busy), .done(done), .halted(halted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
      end
   endtask

   logic [15:0] mem [0:32767];
   int          ack_dly = 0;
   logic        err_en = 1'b0;
   logic [15:0] err_addr = 16'h0;
   int          rsp_cnt = 0;

   // Responder: ack is held until the DUT takes it on a ce cycle.
   always @(posedge clk) begin : rsp
      logic took;
      took = bus_ack && ce && reset_n;
      #1;
      if (took || !bus_req) begin
         bus_ack = 1'b0;
         bus_err = 1'b0;
         rsp_cnt = 0;
      end
      if (bus_req && !bus_ack) begin
         if (rsp_cnt >= ack_dly) begin
            bus_ack   = 1'b1;
            bus_rdata = mem[bus_addr[15:1]];
            bus_err   = err_en && (bus_addr == err_addr);
         end else begin
            rsp_cnt++;
         end
      end
   end

   logic [15:0] wr_addr[$], wr_data[$], rd_addr[$], sp_log[$], pc_log[$], psw_log[$];
   int          done_cnt = 0, ack_cnt = 0, viol = 0;
   logic        p_req = 1'b0, p_took = 1'b0, p_we = 1'b0;
   logic [15:0] p_addr = 16'h0, p_wdata = 16'h0;

   always @(posedge clk) begin
      #8;
      if (bus_req && bus_ack && ce && reset_n && !bus_err) begin
         if (bus_we) begin
            wr_addr.push_back(bus_addr);
            wr_data.push_back(bus_wdata);
         end else begin
            rd_addr.push_back(bus_addr);
         end
      end
      if (sp_load)  sp_log.push_back(sp_out);
      if (pc_load)  pc_log.push_back(pc_out);
      if (psw_load) psw_log.push_back({8'h00, psw_out});
      if (done)     done_cnt++;
      if (irq_ack)  ack_cnt++;
      if (bus_req && p_req && !p_took &&
          (bus_we != p_we || bus_addr != p_addr || bus_wdata != p_wdata))
         viol++;
      p_req   = bus_req;
      p_took  = bus_ack && ce && reset_n;
      p_we    = bus_we;
      p_addr  = bus_addr;
      p_wdata = bus_wdata;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clr();
      wr_addr = {}; wr_data = {}; rd_addr = {};
      sp_log = {}; pc_log = {}; psw_log = {};
      done_cnt = 0; ack_cnt = 0; viol = 0;
   endtask

   task automatic wait_done(input int n, input string tag, input bit toggle_ce);
      int k;
      k = 0;
      while (done_cnt < n && k < 300) begin
         if (toggle_ce) ce = ~ce;
         step();
         k++;
      end
      ce = 1'b1;
      chk(tag, (done_cnt >= n), 1);
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'h0;

      // reset state
      step(3);
      chk("rst_busy", busy, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_halted", halted, 0);
      chk("rst_done", done, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_sp_load", sp_load, 0);
      reset_n = 1'b1;
      step();

      // illegal-instruction trap
      sp = 16'o001000; pc = 16'o002000; psw = 8'o000;
      mem[16'o000010 >> 1] = 16'o003000;
      mem[16'o000012 >> 1] = 16'o000340;
      clr();
      boundary = 1'b1; req_err = 1'b1;
      step();
      boundary = 1'b0; req_err = 1'b0;
      chk("err_busy", busy, 1);
      wait_done(1, "err_done_seen", 1'b0);
      chk("err_wr0_addr", wr_addr[0], 16'o000776);
      chk("err_wr0_data", wr_data[0], 16'o000000);
      chk("err_wr1_addr", wr_addr[1], 16'o000774);
      chk("err_wr1_data", wr_data[1], 16'o002000);
      chk("err_sp0", sp_log[0], 16'o000776);
      chk("err_sp1", sp_log[1], 16'o000774);
      chk("err_rd0", rd_addr[0], 16'o000010);
      chk("err_rd1", rd_addr[1], 16'o000012);
      chk("err_pc", pc_log[0], 16'o003000);
      chk("err_psw", psw_log[0], 16'o000340);
      chk("err_irq_ack", ack_cnt, 0);
      step(2);
      chk("err_done_once", done_cnt, 1);
      chk("err_idle", busy, 0);

      // IRQ masking
      clr();
      mem[16'o000060 >> 1] = 16'o004000;
      mem[16'o000062 >> 1] = 16'o000000;
      irq = 1'b1; irq_vec = 16'o000060; psw = 8'o200; boundary = 1'b1;
      step(5);
      chk("irq_mask4_busy", busy, 0);
      chk("irq_mask4_ack", ack_cnt, 0);
      psw = 8'o340;
      step(5);
      chk("irq_mask7_busy", busy, 0);
      chk("irq_mask7_ack", ack_cnt, 0);
      psw = 8'o000;
      step();
      boundary = 1'b0; irq = 1'b0;
      chk("irq_ack", ack_cnt, 1);
      wait_done(1, "irq_done_seen", 1'b0);
      chk("irq_rd0", rd_addr[0], 16'o000060);
      chk("irq_rd1", rd_addr[1], 16'o000062);
      chk("irq_pc", pc_log[0], 16'o004000);
      step(2);

      // priority: buserr before err
      clr();
      mem[16'o000004 >> 1] = 16'o005000;
      mem[16'o000006 >> 1] = 16'o000000;
      req_buserr = 1'b1; req_err = 1'b1;
      step();
      req_buserr = 1'b0; req_err = 1'b0;
      step();
      boundary = 1'b1;
      step();
      boundary = 1'b0;
      wait_done(1, "prio_done1", 1'b0);
      chk("prio_first_vec", rd_addr[0], 16'o000004);
      chk("prio_first_pc", pc_log[0], 16'o005000);
      step(2);
      boundary = 1'b1;
      step();
      boundary = 1'b0;
      wait_done(2, "prio_done2", 1'b0);
      chk("prio_second_vec", rd_addr[2], 16'o000010);
      step(2);

      // double fault on PUSH_PC
      clr();
      err_en = 1'b1; err_addr = 16'o000774; sp = 16'o001000;
      req_err = 1'b1; boundary = 1'b1;
      step();
      req_err = 1'b0; boundary = 1'b0;
      for (int k = 0; k < 50 && !halted; k++) step();
      chk("df_halted", halted, 1);
      chk("df_wr_cnt", wr_addr.size(), 1);
      chk("df_sp_cnt", sp_log.size(), 1);
      step(10);
      req_err = 1'b1; boundary = 1'b1;
      step();
      req_err = 1'b0; boundary = 1'b0;
      step(3);
      chk("df_bus_req", bus_req, 0);
      chk("df_still_halted", halted, 1);
      chk("df_busy", busy, 1);
      chk("df_pc_cnt", pc_log.size(), 0);
      chk("df_rd_cnt", rd_addr.size(), 0);
      err_en = 1'b0;
      reset_n = 1'b0;
      step();
      chk("df_rst_halted", halted, 0);
      chk("df_rst_busy", busy, 0);
      reset_n = 1'b1;
      step();

      // stalls and stack wrap
      clr();
      sp = 16'o000002; ack_dly = 3;
      req_err = 1'b1; boundary = 1'b1;
      step();
      req_err = 1'b0; boundary = 1'b0;
      wait_done(1, "wrap_done_seen", 1'b1);
      chk("wrap_wr0", wr_addr[0], 16'o000000);
      chk("wrap_wr1", wr_addr[1], 16'o177776);
      chk("wrap_sp0", sp_log[0], 16'o000000);
      chk("wrap_sp1", sp_log[1], 16'o177776);
      chk("wrap_stable", viol, 0);
      step(3);
      chk("wrap_done_once", done_cnt, 1);

      // reset during FETCH_PC
      clr();
      sp = 16'o001000; ack_dly = 4;
      req_err = 1'b1; boundary = 1'b1;
      step();
      req_err = 1'b0; boundary = 1'b0; req_buserr = 1'b1;
      step();
      req_buserr = 1'b0;
      begin
         bit found;
         found = 1'b0;
         for (int k = 0; k < 100 && !found; k++) begin
            if (bus_req && !bus_we && bus_addr == 16'o000010) found = 1'b1;
            else step();
         end
         chk("mid_reached_fetch", found, 1);
      end
      reset_n = 1'b0;
      step();
      chk("mid_busy", busy, 0);
      chk("mid_bus_req", bus_req, 0);
      reset_n = 1'b1; boundary = 1'b1;
      step(6);
      boundary = 1'b0;
      chk("mid_no_pend", busy, 0);
      chk("mid_no_pc_load", pc_log.size(), 0);
      chk("mid_no_reads", rd_addr.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
